// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter for a pipelined shifter with tagged in-order result FIFO; define SHIFT_ARB_FIXED_PRIO_EN for fixed priority
module shift_arbiter #(
    parameter int SH_LAT    = 5,
    parameter int RES_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_amt,
    input  logic        req0_rot,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_amt,
    input  logic        req1_rot,
    output logic [31:0] sh_in,
    output logic [4:0]  sh_sel,
    output logic        sh_rot,
    input  logic [31:0] sh_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_tag
);

    localparam int PW = $clog2(RES_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(SH_LAT + RES_DEPTH + 1);

    logic [SH_LAT-1:0]    vline;
    logic [SH_LAT-1:0]    tline;
    logic [31:0]          fifo_data [RES_DEPTH];
    logic [RES_DEPTH-1:0] fifo_tag;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [OW-1:0]        occ;
    logic                 can_issue;
    logic                 grant;
    logic                 winner;
    logic                 push;
    logic                 pop;
    logic                 full;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic rr;
`endif

    // Credits: every issued request owns a FIFO slot until it is popped
    always_comb begin
        occ = OW'(count);
        for (int i = 0; i < SH_LAT; i++) begin
            occ = occ + OW'(vline[i]);
        end
    end

    assign can_issue = (occ < OW'(RES_DEPTH));

    // Pick at most one requester per cycle, only when a result slot is free
    always_comb begin
        grant  = 1'b0;
        winner = 1'b0;
        if (can_issue) begin
            if (req0_valid && req1_valid) begin
                grant = 1'b1;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
                winner = 1'b0;
`else
                winner = rr;
`endif
            end else if (req0_valid) begin
                grant  = 1'b1;
                winner = 1'b0;
            end else if (req1_valid) begin
                grant  = 1'b1;
                winner = 1'b1;
            end
        end
    end

    assign req0_ready = grant & ~winner;
    assign req1_ready = grant & winner;

    // Present the winner's operands to the shifter; idle cycles drive zeros
    always_comb begin
        sh_in  = '0;
        sh_sel = '0;
        sh_rot = 1'b0;
        if (grant) begin
            sh_in  = winner ? req1_data : req0_data;
            sh_sel = winner ? req1_amt  : req0_amt;
            sh_rot = winner ? req1_rot  : req0_rot;
        end
    end

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    // After any grant the other requester gets first claim on the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (grant) begin
            rr <= ~winner;
        end
    end
`endif

    // Valid/tag delay line aligned with the shifter so its output is claimed exactly once
    always_ff @(posedge clk) begin
        if (rst) begin
            vline <= '0;
            tline <= '0;
        end else begin
            vline[0] <= grant;
            tline[0] <= winner;
            for (int i = 1; i < SH_LAT; i++) begin
                vline[i] <= vline[i-1];
                tline[i] <= tline[i-1];
            end
        end
    end

    assign push       = vline[SH_LAT-1];
    assign resp_valid = (count != '0);
    assign pop        = resp_valid & resp_ready;
    assign full       = (count == CW'(RES_DEPTH));
    assign resp_data  = resp_valid ? fifo_data[rd_ptr] : '0;
    assign resp_tag   = resp_valid ? fifo_tag[rd_ptr] : 1'b0;

    // Result storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= sh_out;
            fifo_tag[wr_ptr]  <= tline[SH_LAT-1];
        end
    end

    // FIFO pointers and count; push into a full FIFO without a pop cannot happen with credits
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter with a 5-stage shifter model
module tb_shift_arbiter;

    localparam int SH_LAT = 5;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_rot;
    logic [31:0] req0_data;
    logic [4:0]  req0_amt;
    logic        req1_valid, req1_ready, req1_rot;
    logic [31:0] req1_data;
    logic [4:0]  req1_amt;
    logic [31:0] sh_in, sh_out;
    logic [4:0]  sh_sel;
    logic        sh_rot;
    logic        resp_valid, resp_ready, resp_tag;
    logic [31:0] resp_data;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int outstanding = 0;
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    int          got_cyc[$];
    logic [31:0] pipe [SH_LAT];

    shift_arbiter #(.SH_LAT(5), .RES_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_rot(req0_rot),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_rot(req1_rot),
        .sh_in(sh_in), .sh_sel(sh_sel), .sh_rot(sh_rot), .sh_out(sh_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a, input logic r);
        logic [63:0] w;
        w = {d, d} >> a;
        return r ? w[31:0] : (d >> a);
    endfunction

    // External shifter: fixed 5-cycle pipeline, no stall
    always @(posedge clk) begin
        pipe[0] <= ref_shift(sh_in, sh_sel, sh_rot);
        for (int i = 1; i < SH_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sh_out = pipe[SH_LAT-1];

    // Collect responses and track accepted-but-unpopped requests mid-cycle
    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (rst) begin
            outstanding = 0;
        end else begin
            if (req0_valid && req0_ready) outstanding = outstanding + 1;
            if (req1_valid && req1_ready) outstanding = outstanding + 1;
            if (resp_valid && resp_ready) begin
                got_q.push_back({resp_tag, resp_data});
                got_cyc.push_back(cyc_n);
                outstanding = outstanding - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic [4:0] a0, input logic r0,
                         input logic v1, input logic [31:0] d1, input logic [4:0] a1, input logic r1,
                         output logic g0, output logic g1);
        req0_valid = v0; req0_data = d0; req0_amt = a0; req0_rot = r0;
        req1_valid = v1; req1_data = d1; req1_amt = a1; req1_rot = r1;
        #1;
        g0 = req0_ready;
        g1 = req1_ready;
        if (req0_valid && req0_ready) exp_q.push_back({1'b0, ref_shift(d0, a0, r0)});
        if (req1_valid && req1_ready) exp_q.push_back({1'b1, ref_shift(d1, a1, r1)});
    endtask

    task automatic idle();
        logic g0, g1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, g0, g1);
    endtask

    task automatic wait_drain(input int maxc, output logic ok);
        ok = 1'b0;
        resp_ready = 1'b1;
        idle();
        for (int k = 0; k < maxc; k++) begin
            if (outstanding == 0) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        resp_ready = 1'b0;
        idle();
        cyc();
        cyc();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failures++; $display("FAIL reset_ready got=%b need=00", {req0_ready, req1_ready});
        end
        checks++;
        if ({resp_valid, resp_data, resp_tag} !== 34'h0) begin
            failures++; $display("FAIL reset_resp got=%b/%h/%b need=0/0/0", resp_valid, resp_data, resp_tag);
        end
        checks++;
        if ({sh_in, sh_sel, sh_rot} !== 38'h0) begin
            failures++; $display("FAIL reset_sh got=%h/%h/%b need=0/0/0", sh_in, sh_sel, sh_rot);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release_valid got=%b need=0", resp_valid);
        end
    endtask

    task automatic test_single();
        logic g0, g1, ok;
        int first;
        logic [31:0] d;
        logic t;
        clear_q();
        resp_ready = 1'b1;
        first = 0; d = 32'h0; t = 1'b1;
        drive(1'b1, 32'h8000_0001, 5'd1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, g0, g1);
        checks++;
        if ({g0, g1} !== 2'b10) begin
            failures++; $display("FAIL single_grant got=%b need=10", {g0, g1});
        end
        checks++;
        if ({sh_in, sh_sel, sh_rot} !== {32'h8000_0001, 5'd1, 1'b1}) begin
            failures++; $display("FAIL single_sh_drive got=%h/%h/%b need=80000001/01/1", sh_in, sh_sel, sh_rot);
        end
        cyc();
        idle();
        for (int k = 1; k <= 20; k++) begin
            if (resp_valid) begin
                first = k; d = resp_data; t = resp_tag;
                break;
            end
            cyc();
        end
        checks++;
        if (first != 6) begin
            failures++; $display("FAIL single_latency got=%0d need=6", first);
        end
        checks++;
        if ({t, d} !== {1'b0, 32'hC000_0000}) begin
            failures++; $display("FAIL single_result got=%b/%h need=0/c0000000", t, d);
        end
        wait_drain(20, ok);
        clear_q();
    endtask

    task automatic test_shift_rotate();
        logic g0, g1, ok;
        clear_q();
        resp_ready = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hF000_000F, 5'd4, 1'b0, g0, g1);
        cyc();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hF000_000F, 5'd4, 1'b1, g0, g1);
        cyc();
        wait_drain(30, ok);
        checks++;
        if (got_q.size() != 2) begin
            failures++; $display("FAIL shrot_count got=%0d need=2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {1'b1, 32'h0F00_0000}) begin
                failures++; $display("FAIL shrot_shift got=%h need=10f000000", got_q[0]);
            end
            checks++;
            if (got_q[1] !== {1'b1, 32'hFF00_0000}) begin
                failures++; $display("FAIL shrot_rotate got=%h need=1ff000000", got_q[1]);
            end
        end
        clear_q();
    endtask

    task automatic test_contention();
        logic [31:0] a [17];
        logic [31:0] b [17];
        logic [4:0]  aa [17];
        logic [4:0]  ba [17];
        logic g0, g1, ok, bad;
        int i0, i1;
        logic [32:0] e, g;
        clear_q();
        resp_ready = 1'b1;
        i0 = 0; i1 = 0; bad = 1'b0;
        for (int k = 0; k < 17; k++) begin
            a[k] = $urandom; b[k] = $urandom;
            aa[k] = 5'($urandom_range(0, 31)); ba[k] = 5'($urandom_range(0, 31));
        end
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, a[i0], aa[i0], c[0], 1'b1, b[i1], ba[i1], ~c[0], g0, g1);
            if (g0 && g1) bad = 1'b1;
            if (g0) i0++;
            if (g1) i1++;
            cyc();
        end
        wait_drain(30, ok);
        checks++;
        if (!ok || bad) begin
            failures++; $display("FAIL cont_drain ok=%b double_grant=%b need ok=1 double=0", ok, bad);
        end
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        checks++;
        if (i0 != 16 || i1 != 0) begin
            failures++; $display("FAIL cont_grants got=%0d/%0d need=16/0", i0, i1);
        end
`else
        checks++;
        if (i0 != 8 || i1 != 8) begin
            failures++; $display("FAIL cont_grants got=%0d/%0d need=8/8", i0, i1);
        end
`endif
        checks++;
        if (got_q.size() != 16) begin
            failures++; $display("FAIL cont_count got=%0d need=16", got_q.size());
        end else begin
            bad = 1'b0;
            for (int k = 0; k < 16; k++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
                if (got_q[k][32] !== 1'b0) bad = 1'b1;
`else
                if (got_q[k][32] !== k[0]) bad = 1'b1;
`endif
            end
            checks++;
            if (bad) begin
                failures++; $display("FAIL cont_tag_order got first tags %b%b%b%b need alternating from 0 (or all 0 fixed)",
                                     got_q[0][32], got_q[1][32], got_q[2][32], got_q[3][32]);
            end
            checks++;
            if (got_cyc[15] - got_cyc[0] != 15) begin
                failures++; $display("FAIL cont_throughput got=%0d need=15 cycles for 16 results", got_cyc[15] - got_cyc[0]);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL cont_sb got=%h need=%h", g, e);
            end
        end
        clear_q();
    endtask

    task automatic test_back_to_back_backpressure();
        logic g0, g1, ok;
        int grants;
        logic [32:0] e, g;
        clear_q();
        resp_ready = 1'b0;
        grants = 0;
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), g0, g1);
            if (g0 || g1) grants++;
            cyc();
        end
        checks++;
        if (grants != 8) begin
            failures++; $display("FAIL bp_grants got=%0d need=8", grants);
        end
        resp_ready = 1'b1;
        drive(1'b1, $urandom, 5'd3, 1'b0, 1'b1, $urandom, 5'd7, 1'b1, g0, g1);
        checks++;
        if ({g0, g1} !== 2'b00) begin
            failures++; $display("FAIL bp_pop_cycle_grant got=%b need=00", {g0, g1});
        end
        cyc();
        resp_ready = 1'b0;
        drive(1'b1, $urandom, 5'd3, 1'b0, 1'b1, $urandom, 5'd7, 1'b1, g0, g1);
        checks++;
        if ((g0 ^ g1) !== 1'b1) begin
            failures++; $display("FAIL bp_regrant got=%b need=one grant", {g0, g1});
        end
        cyc();
        drive(1'b1, $urandom, 5'd3, 1'b0, 1'b1, $urandom, 5'd7, 1'b1, g0, g1);
        checks++;
        if ({g0, g1} !== 2'b00) begin
            failures++; $display("FAIL bp_full_again got=%b need=00", {g0, g1});
        end
        cyc();
        wait_drain(40, ok);
        checks++;
        if (!ok || exp_q.size() != 9 || got_q.size() != 9) begin
            failures++; $display("FAIL bp_totals got drain=%b exp=%0d resp=%0d need 1/9/9", ok, exp_q.size(), got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL bp_sb got=%h need=%h", g, e);
            end
        end
        clear_q();
    endtask

    task automatic test_reset_midflight();
        logic g0, g1, ok, saw;
        int n, first;
        logic [31:0] d;
        logic t;
        clear_q();
        resp_ready = 1'b1;
        n = 0; saw = 1'b0; first = 0; d = 32'h0; t = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, $urandom, 5'd2, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, g0, g1);
            if (g0) n++;
            cyc();
        end
        idle();
        cyc();
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
        clear_q();
        checks++;
        if (n != 3) begin
            failures++; $display("FAIL rstmid_issue got=%0d need=3", n);
        end
        for (int c = 0; c < 12; c++) begin
            if (resp_valid) saw = 1'b1;
            cyc();
        end
        checks++;
        if (saw !== 1'b0) begin
            failures++; $display("FAIL rstmid_stale_resp got=%b need=0", saw);
        end
        drive(1'b1, 32'h1234_5678, 5'd8, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd3, 1'b0, g0, g1);
        checks++;
        if ({g0, g1} !== 2'b10) begin
            failures++; $display("FAIL rstmid_rr got=%b need=10", {g0, g1});
        end
        cyc();
        idle();
        for (int k = 1; k <= 20; k++) begin
            if (resp_valid) begin
                first = k; d = resp_data; t = resp_tag;
                break;
            end
            cyc();
        end
        checks++;
        if (first != 6 || {t, d} !== {1'b0, 32'h7812_3456}) begin
            failures++; $display("FAIL rstmid_result got=%0d/%b/%h need=6/0/78123456", first, t, d);
        end
        wait_drain(20, ok);
        clear_q();
    endtask

    task automatic test_random();
        logic g0, g1, ok, v0, v1;
        logic [32:0] e, g;
        clear_q();
        for (int c = 0; c < 300; c++) begin
            v0 = ($urandom_range(0, 9) < 6);
            v1 = ($urandom_range(0, 9) < 6);
            resp_ready = 1'($urandom_range(0, 1));
            drive(v0, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  v1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), g0, g1);
            checks++;
            if ((g0 && !v0) || (g1 && !v1) || (g0 && g1)) begin
                failures++; $display("FAIL rand_ready_protocol got=%b%b valid=%b%b", g0, g1, v0, v1);
            end
            checks++;
            if (outstanding > 8 || ((g0 | g1) !== ((v0 | v1) && outstanding < 8))) begin
                failures++; $display("FAIL rand_credit occ=%0d grant=%b need grant=%b", outstanding, g0 | g1,
                                     (v0 | v1) && outstanding < 8);
            end
            cyc();
        end
        wait_drain(40, ok);
        checks++;
        if (!ok || exp_q.size() != got_q.size()) begin
            failures++; $display("FAIL rand_totals got drain=%b exp=%0d resp=%0d", ok, exp_q.size(), got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL rand_sb got=%h need=%h", g, e);
            end
        end
        clear_q();
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_rot = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_rot = 1'b0;
        test_reset();
        test_single();
        test_shift_rotate();
        test_contention();
        test_back_to_back_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the 5-stage pipelined 32-bit right shift/rotate unit between two requesters. Each accepted request is tagged, issued to the shifter, and tracked through a valid/tag delay line that matches the shifter latency. Results are written into a tagged result FIFO and returned in issue order. Credit accounting guarantees that no result is lost, because the shifter pipeline cannot stall.

## Interface
Parameters:
- SH_LAT, 5: shifter latency in cycles, from operand presentation to result on sh_out.
- RES_DEPTH, 8: result FIFO depth; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready).
- req0_data / req1_data  in  32  operand.
- req0_amt / req1_amt  in  5  shift/rotate amount.
- req0_rot / req1_rot  in  1  1 = rotate right, 0 = logical shift right.
- sh_in  out  32  operand to shifter.
- sh_sel  out  5  amount to shifter.
- sh_rot  out  1  rotate control to shifter.
- sh_out  in  32  shifter result.
- resp_valid  out  1  FIFO head valid.
- resp_ready  in  1  consumer accepts head.
- resp_data  out  32  result.
- resp_tag  out  1  originating requester (0/1).

## Operation
- Occupancy: occ = inflight + fifo_count, where inflight = number of set bits in the valid delay line.
- can_issue = (occ < RES_DEPTH). Credit is reserved at issue and released at FIFO pop.
- Grant when can_issue is true:
  - Only one requester valid: that requester wins.
  - Both valid: round-robin pointer rr picks the winner. After a grant, rr points to the other requester.
  - rr reset value is 0, so requester 0 wins first.
- reqN_ready = grant to N. reqN_ready never asserts without reqN_valid.
- Shifter drive on a grant: combinationally drives sh_in/sh_sel/sh_rot from the winning request in the grant cycle.
- Shifter drive with no grant: sh_in = 0, sh_sel = 0, sh_rot = 0.
- Delay line: SH_LAT stages of {valid, tag}. Stage 0 captures {grant, winner} at the grant edge.
- Push: when the last stage is valid, sh_out and the tag are pushed into the FIFO at the next edge.
  - The push is guaranteed to succeed by construction.
  - A push attempted while the FIFO is full is a design error; assertion only.
- Pop: resp_valid & resp_ready pops the head.
  - Simultaneous push and pop is allowed at any count, including full and empty.
  - Push on empty with simultaneous no-pop: head becomes visible the next cycle. There is no FIFO bypass.
- Ordering: results leave in global issue order. Per-requester order is preserved.
- Reset behaviour:
  - Clears the delay line, FIFO pointers/count and rr.
  - Reset mid-operation discards all in-flight and buffered results.
  - Stale shifter contents are ignored because the delay-line valids are cleared.
- Reset values:
  - req0_ready = req1_ready = 0.
  - resp_valid = 0, resp_data = 0, resp_tag = 0.
  - sh_in = sh_sel = sh_rot = 0.

## Timing
- Grant at cycle T → shifter result on sh_out in cycle T+SH_LAT.
- FIFO write at the end of T+SH_LAT; resp_valid earliest in cycle T+SH_LAT+1. Total latency is 6 cycles at default.
- Throughput: 1 request/cycle sustained while resp_ready = 1.
- With resp_ready held at 0: exactly RES_DEPTH grants are issued, then both readies stay 0 until a pop.
- A pop in cycle P makes can_issue true in cycle P+1 (occ is registered).
- Round-robin applies only on cycles where both requesters are valid and can_issue holds.
- A requester waiting behind the other is granted within 2 issue opportunities.

## Configuration
- SHIFT_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 has strict priority; rr is removed; requester 1 is granted only when req0_valid = 0.
  - Undefined (default): round-robin as above.
  - All other behaviour is identical in both builds.

## Test plan
- Single request: req0 = {0x8000_0001, amt 1, rot 1} granted at T → resp at T+6 with data 0xC000_0000, tag 0.
- Shift vs rotate: req1 = {0xF000_000F, amt 4, rot 0} → resp 0x0F00_0000, tag 1. Same operand with rot 1 → 0xFF00_0000.
- Contention: both valid every cycle, resp_ready = 1 → tags alternate 0,1,0,1…; 1 result/cycle after a 6-cycle fill. With SHIFT_ARB_FIXED_PRIO_EN defined → all tags 0 and req1 is never granted.
- Backpressure: resp_ready = 0, both requesters streaming → exactly 8 grants, then readies stay 0. One pop → one new grant the following cycle; no result lost or duplicated; order matches issue order.
- Reset mid-flight: 3 requests issued, rst asserted 2 cycles later for one cycle → no resp_valid afterwards for those requests. The next request returns the correct result at +6 with tag per rr = 0.
- Random amounts 0–31 with mixed rot and random resp_ready → scoreboard matches a reference shift/rotate model; the occupancy invariant occ ≤ 8 always holds.
